// File: rtl/rtc_bus_timing_ctrl.sv
// Address/data phase timing generator for the external RTC bus driver.
// All outputs are registered and decoded from the next state.
module rtc_bus_timing_ctrl #(
  parameter int T_SU  = 2,
  parameter int T_PW  = 4,
  parameter int T_HD  = 2,
  parameter int T_GAP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       out_flag_escritura,
  output logic       out_flag_lectura,
  output logic [7:0] out_dato_bus,
  input  logic [7:0] in_dato_bus,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_A_SU = 4'd1;
  localparam logic [3:0] S_A_PW = 4'd2;
  localparam logic [3:0] S_A_HD = 4'd3;
  localparam logic [3:0] S_GAP  = 4'd4;
  localparam logic [3:0] S_D_SU = 4'd5;
  localparam logic [3:0] S_D_PW = 4'd6;
  localparam logic [3:0] S_D_HD = 4'd7;
  localparam logic [3:0] S_DONE = 4'd8;

  localparam logic [7:0] SU_M1  = 8'(T_SU - 1);
  localparam logic [7:0] PW_M1  = 8'(T_PW - 1);
  localparam logic [7:0] HD_M1  = 8'(T_HD - 1);
  localparam logic [7:0] GAP_M1 = 8'(T_GAP - 1);

  logic [3:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       fe_q, fe_d;
  logic       fl_q, fl_d;
  logic [7:0] dbus_q, dbus_d;
  logic       cs_n_q, cs_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       a_d_q, a_d_d;

  // Next state, dwell counter, request latch and read capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_A_SU;
        cnt_d   = SU_M1;
        rw_d    = rw;
        addr_d  = addr;
        wdata_d = wdata;
      end
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      case (state_q)
        S_A_SU: begin state_d = S_A_PW; cnt_d = PW_M1;  end
        S_A_PW: begin state_d = S_A_HD; cnt_d = HD_M1;  end
        S_A_HD: begin state_d = S_GAP;  cnt_d = GAP_M1; end
        S_GAP:  begin state_d = S_D_SU; cnt_d = SU_M1;  end
        S_D_SU: begin state_d = S_D_PW; cnt_d = PW_M1;  end
        S_D_PW: begin
          state_d = S_D_HD;
          cnt_d   = HD_M1;
          if (!rw_q) rdata_d = in_dato_bus;
        end
        S_D_HD: begin state_d = S_DONE; cnt_d = 8'd0; end
        default: begin state_d = S_IDLE; cnt_d = 8'd0; end
      endcase
    end
  end

  // Moore output decode from the state being entered
  always_comb begin
    cs_n_d = 1'b1;
    rd_n_d = 1'b1;
    wr_n_d = 1'b1;
    a_d_d  = 1'b1;
    fe_d   = 1'b0;
    fl_d   = 1'b0;
    dbus_d = 8'd0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    case (state_d)
      S_A_SU, S_A_PW, S_A_HD: begin
        a_d_d  = 1'b0;
        cs_n_d = 1'b0;
        fe_d   = 1'b1;
        dbus_d = addr_d;
        wr_n_d = (state_d != S_A_PW);
      end
      S_D_SU, S_D_PW, S_D_HD: begin
        cs_n_d = 1'b0;
        if (rw_d) begin
          fe_d   = 1'b1;
          dbus_d = wdata_d;
          wr_n_d = (state_d != S_D_PW);
        end else begin
          fl_d   = 1'b1;
          rd_n_d = (state_d != S_D_PW);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      rw_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fe_q    <= 1'b0;
      fl_q    <= 1'b0;
      dbus_q  <= 8'd0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      a_d_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fe_q    <= fe_d;
      fl_q    <= fl_d;
      dbus_q  <= dbus_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      a_d_q   <= a_d_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign rdata              = rdata_q;
  assign out_flag_escritura = fe_q;
  assign out_flag_lectura   = fl_q;
  assign out_dato_bus       = dbus_q;
  assign cs_n               = cs_n_q;
  assign rd_n               = rd_n_q;
  assign wr_n               = wr_n_q;
  assign a_d                = a_d_q;

endmodule

// File: tb/tb_rtc_bus_timing_ctrl.sv
// Directed bench for rtc_bus_timing_ctrl: default-timing instance plus an
// all-ones timing instance driven from the same stimulus.
module tb_rtc_bus_timing_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] in_dato_bus = 8'd0;

  logic       busy, done, fe, fl, cs_n, rd_n, wr_n, a_d;
  logic [7:0] rdata, dbus;
  logic       f_busy, f_done, f_fe, f_fl, f_cs_n, f_rd_n, f_wr_n, f_a_d;
  logic [7:0] f_rdata, f_dbus;

  int n_chk = 0;
  int n_fail = 0;
  logic inv_en = 1'b0;

  always #5 clk = ~clk;

  rtc_bus_timing_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .out_flag_escritura(fe), .out_flag_lectura(fl), .out_dato_bus(dbus),
    .in_dato_bus(in_dato_bus), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d)
  );

  rtc_bus_timing_ctrl #(.T_SU(1), .T_PW(1), .T_HD(1), .T_GAP(1)) dut_fast (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .busy(f_busy), .done(f_done), .rdata(f_rdata),
    .out_flag_escritura(f_fe), .out_flag_lectura(f_fl), .out_dato_bus(f_dbus),
    .in_dato_bus(in_dato_bus), .cs_n(f_cs_n), .rd_n(f_rd_n), .wr_n(f_wr_n), .a_d(f_a_d)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Per-cycle capture, bit c = value during cycle c after the accepting edge
  logic [31:0] v_ad, v_csn, v_wrn, v_rdn, v_fe, v_fl, v_done, v_busy;
  logic [31:0] vf_ad, vf_wrn, vf_done, vf_busy;
  logic [7:0]  a_dbus [0:31];
  logic [7:0]  a_rdata [0:31];

  logic p_csn, p_ad, pf_csn, pf_ad;
  always @(negedge clk) begin
    if (inv_en) begin
      chk("inv_flags", 32'(fe & fl), 32'd0);
      chk("inv_strobes", 32'(!rd_n && !wr_n), 32'd0);
      chk("inv_ad_stable", 32'(!p_csn && !cs_n && (p_ad != a_d)), 32'd0);
      chk("inv_flags_fast", 32'(f_fe & f_fl), 32'd0);
      chk("inv_strobes_fast", 32'(!f_rd_n && !f_wr_n), 32'd0);
      chk("inv_ad_stable_fast", 32'(!pf_csn && !f_cs_n && (pf_ad != f_a_d)), 32'd0);
    end
    p_csn  = cs_n;   p_ad  = a_d;
    pf_csn = f_cs_n; pf_ad = f_a_d;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic run(input logic t_rw, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                     input int pa, input int pb, input int rst_at);
    v_ad = '0; v_csn = '0; v_wrn = '0; v_rdn = '0; v_fe = '0; v_fl = '0;
    v_done = '0; v_busy = '0; vf_ad = '0; vf_wrn = '0; vf_done = '0; vf_busy = '0;
    @(posedge clk); #1;
    start = 1'b1; rw = t_rw; addr = t_addr; wdata = t_wdata;
    @(posedge clk); #1;
    start = 1'b0; rw = ~t_rw; addr = 8'h55; wdata = 8'h66;
    for (int c = 1; c <= 22; c++) begin
      v_ad[c] = a_d; v_csn[c] = cs_n; v_wrn[c] = wr_n; v_rdn[c] = rd_n;
      v_fe[c] = fe; v_fl[c] = fl; v_done[c] = done; v_busy[c] = busy;
      vf_ad[c] = f_a_d; vf_wrn[c] = f_wr_n; vf_done[c] = f_done; vf_busy[c] = f_busy;
      a_dbus[c] = dbus; a_rdata[c] = rdata;
      start = (c == pa) || (c == pb);
      if (start) begin addr = 8'h10; wdata = 8'h99; rw = 1'b1; end
      in_dato_bus = (c >= 14 && c <= 17) ? 8'h37 : 8'hAA;
      reset = (c == rst_at);
      @(posedge clk); #1;
    end
    start = 1'b0; reset = 1'b0;
  endtask

  initial begin
    logic [31:0] all;
    all = mk(1, 22);
    do_reset();
    #4;
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_rd_wr_n", 32'({rd_n, wr_n}), 32'd3);
    chk("rst_a_d", 32'(a_d), 32'd1);
    chk("rst_flags", 32'({fe, fl}), 32'd0);
    chk("rst_dbus", 32'(dbus), 32'd0);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    inv_en = 1'b1;

    // Write with defaults; fast instance runs the same request
    run(1'b1, 8'h21, 8'h45, 0, 0, 0);
    chk("wr_a_d", v_ad, mk(9, 22));
    chk("wr_cs_n", v_csn, mk(9, 11) | mk(20, 22));
    chk("wr_wr_n", v_wrn, all & ~(mk(3, 6) | mk(14, 17)));
    chk("wr_rd_n", v_rdn, all);
    chk("wr_fe", v_fe, mk(1, 8) | mk(12, 19));
    chk("wr_fl", v_fl, 32'd0);
    chk("wr_done", v_done, mk(20, 20));
    chk("wr_busy", v_busy, mk(1, 20));
    chk("wr_dbus_c1", 32'(a_dbus[1]), 32'h21);
    chk("wr_dbus_c3", 32'(a_dbus[3]), 32'h21);
    chk("wr_dbus_c8", 32'(a_dbus[8]), 32'h21);
    chk("wr_dbus_c9", 32'(a_dbus[9]), 32'h00);
    chk("wr_dbus_c14", 32'(a_dbus[14]), 32'h45);
    chk("wr_dbus_c19", 32'(a_dbus[19]), 32'h45);
    chk("wr_dbus_c20", 32'(a_dbus[20]), 32'h00);
    chk("wr_rdata", 32'(a_rdata[22]), 32'h00);
    chk("fast_wr_n", vf_wrn, all & ~(mk(2, 2) | mk(6, 6)));
    chk("fast_a_d", vf_ad, mk(4, 22));
    chk("fast_done", vf_done, mk(8, 8));
    chk("fast_busy", vf_busy, mk(1, 8));

    // Read with defaults
    do_reset();
    run(1'b0, 8'h22, 8'h99, 0, 0, 0);
    chk("rd_rd_n", v_rdn, all & ~mk(14, 17));
    chk("rd_wr_n", v_wrn, all & ~mk(3, 6));
    chk("rd_fl", v_fl, mk(12, 19));
    chk("rd_fe", v_fe, mk(1, 8));
    chk("rd_dbus_c3", 32'(a_dbus[3]), 32'h22);
    chk("rd_dbus_c14", 32'(a_dbus[14]), 32'h00);
    chk("rd_rdata_c17", 32'(a_rdata[17]), 32'h00);
    chk("rd_rdata_c18", 32'(a_rdata[18]), 32'h37);
    chk("rd_rdata_c22", 32'(a_rdata[22]), 32'h37);
    chk("rd_done", v_done, mk(20, 20));

    // A following write must leave rdata untouched
    run(1'b1, 8'h30, 8'h5A, 0, 0, 0);
    chk("wr_keeps_rdata", 32'(a_rdata[22]), 32'h37);

    // Start pulses while busy (cycle 5) and in DONE (cycle 20)
    do_reset();
    run(1'b1, 8'h21, 8'h45, 5, 20, 0);
    chk("bz_dbus_c7", 32'(a_dbus[7]), 32'h21);
    chk("bz_dbus_c14", 32'(a_dbus[14]), 32'h45);
    chk("bz_wr_n", v_wrn, all & ~(mk(3, 6) | mk(14, 17)));
    chk("bz_rd_n", v_rdn, all);
    chk("bz_busy", v_busy, mk(1, 20));
    chk("bz_done", v_done, mk(20, 20));

    // Reset in cycle 15, mid data strobe
    do_reset();
    run(1'b1, 8'h21, 8'h45, 0, 0, 15);
    chk("mr_busy", v_busy, mk(1, 15));
    chk("mr_cs_n", v_csn, mk(9, 11) | mk(16, 22));
    chk("mr_wr_n", v_wrn, all & ~(mk(3, 6) | mk(14, 15)));
    chk("mr_fe", v_fe, mk(1, 8) | mk(12, 15));
    chk("mr_done", v_done, 32'd0);
    chk("mr_dbus_c16", 32'(a_dbus[16]), 32'h00);
    run(1'b1, 8'h3C, 8'hC3, 0, 0, 0);
    chk("mr_again_done", v_done, mk(20, 20));
    chk("mr_again_dbus", 32'(a_dbus[14]), 32'hC3);
    chk("mr_again_wr_n", v_wrn, all & ~(mk(3, 6) | mk(14, 17)));

    inv_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
